// File: rtl/maxmin_pkg.sv
// Shared definitions for the framed max/min tracker: state encoding and
// index-width derivation.
package maxmin_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // A single-sample frame still needs a 1-bit index port.
  function automatic int idx_width(input int frame);
    return (frame <= 1) ? 1 : $clog2(frame);
  endfunction

endpackage

// File: rtl/maxmin_cmp.sv
// Combinational candidate-versus-extremes comparator, signed or unsigned
// depending on SIGNED.
module maxmin_cmp #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic [WIDTH-1:0] cand,
  input  logic [WIDTH-1:0] cur_max,
  input  logic [WIDTH-1:0] cur_min,
  output logic             gt_max,
  output logic             lt_min
);

  generate
    if (SIGNED) begin : g_signed
      assign gt_max = $signed(cand) > $signed(cur_max);
      assign lt_min = $signed(cand) < $signed(cur_min);
    end else begin : g_unsigned
      assign gt_max = cand > cur_max;
      assign lt_min = cand < cur_min;
    end
  endgenerate

endmodule

// File: rtl/maxmin_frame.sv
// Streaming max/min tracker: splits the valid-qualified sample stream into
// frames of FRAME samples and reports extremes plus their in-frame indices.
module maxmin_frame
  import maxmin_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int FRAME  = 16,
  parameter  bit SIGNED = 1'b1,
  localparam int IDXW   = idx_width(FRAME)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic [WIDTH-1:0] dout_max,
  output logic [WIDTH-1:0] dout_min,
  output logic [IDXW-1:0]  max_idx,
  output logic [IDXW-1:0]  min_idx,
  output logic             rdy,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [IDXW-1:0]  cnt_reg, cnt_next;
  logic [WIDTH-1:0] run_max_reg, run_max_next, run_min_reg, run_min_next;
  logic [IDXW-1:0]  run_maxi_reg, run_maxi_next, run_mini_reg, run_mini_next;
  logic [WIDTH-1:0] out_max_reg, out_max_next, out_min_reg, out_min_next;
  logic [IDXW-1:0]  out_maxi_reg, out_maxi_next, out_mini_reg, out_mini_next;
  logic             rdy_reg, rdy_next;
  logic             busy_reg, busy_next;

  logic             gt_max, lt_min;
  logic             first, last;
  logic [WIDTH-1:0] mrg_max, mrg_min;
  logic [IDXW-1:0]  mrg_maxi, mrg_mini;

  maxmin_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp (
    .cand    (din),
    .cur_max (run_max_reg),
    .cur_min (run_min_reg),
    .gt_max  (gt_max),
    .lt_min  (lt_min)
  );

  // The first sample of a frame seeds the extremes; later ones replace them
  // only on a strict win so the earliest occurrence keeps a tie.
  assign first    = (state_reg == ST_EMPTY);
  assign last     = (cnt_reg == IDXW'(FRAME - 1));
  assign mrg_max  = (first || gt_max) ? din : run_max_reg;
  assign mrg_min  = (first || lt_min) ? din : run_min_reg;
  assign mrg_maxi = first ? '0 : (gt_max ? cnt_reg : run_maxi_reg);
  assign mrg_mini = first ? '0 : (lt_min ? cnt_reg : run_mini_reg);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    run_max_next  = run_max_reg;
    run_min_next  = run_min_reg;
    run_maxi_next = run_maxi_reg;
    run_mini_next = run_mini_reg;
    out_max_next  = out_max_reg;
    out_min_next  = out_min_reg;
    out_maxi_next = out_maxi_reg;
    out_mini_next = out_mini_reg;
    rdy_next      = 1'b0;

    if (clr) begin
      state_next    = ST_EMPTY;
      cnt_next      = '0;
      run_max_next  = '0;
      run_min_next  = '0;
      run_maxi_next = '0;
      run_mini_next = '0;
    end else if (din_valid) begin
      if (last) begin
        out_max_next  = mrg_max;
        out_min_next  = mrg_min;
        out_maxi_next = mrg_maxi;
        out_mini_next = mrg_mini;
        rdy_next      = 1'b1;
        cnt_next      = '0;
        state_next    = ST_EMPTY;
      end else begin
        run_max_next  = mrg_max;
        run_min_next  = mrg_min;
        run_maxi_next = mrg_maxi;
        run_mini_next = mrg_mini;
        cnt_next      = cnt_reg + IDXW'(1);
        state_next    = ST_ACCUM;
      end
    end

    busy_next = (cnt_next != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_EMPTY;
      cnt_reg      <= '0;
      run_max_reg  <= '0;
      run_min_reg  <= '0;
      run_maxi_reg <= '0;
      run_mini_reg <= '0;
      out_max_reg  <= '0;
      out_min_reg  <= '0;
      out_maxi_reg <= '0;
      out_mini_reg <= '0;
      rdy_reg      <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      run_max_reg  <= run_max_next;
      run_min_reg  <= run_min_next;
      run_maxi_reg <= run_maxi_next;
      run_mini_reg <= run_mini_next;
      out_max_reg  <= out_max_next;
      out_min_reg  <= out_min_next;
      out_maxi_reg <= out_maxi_next;
      out_mini_reg <= out_mini_next;
      rdy_reg      <= rdy_next;
      busy_reg     <= busy_next;
    end
  end

  assign dout_max = out_max_reg;
  assign dout_min = out_min_reg;
  assign max_idx  = out_maxi_reg;
  assign min_idx  = out_mini_reg;
  assign rdy      = rdy_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_maxmin_frame.sv
// Directed bench for maxmin_frame: signed and unsigned FRAME=16 instances
// plus a FRAME=1 instance, all fed from the same stimulus.
module tb_maxmin_frame;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din_valid = 1'b0;
  logic [15:0] din = '0;
  logic        clr = 1'b0;

  logic [15:0] s_max, s_min, u_max, u_min, f_max, f_min;
  logic [3:0]  s_maxi, s_mini, u_maxi, u_mini;
  logic [0:0]  f_maxi, f_mini;
  logic        s_rdy, s_busy, u_rdy, u_busy, f_rdy, f_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  maxmin_frame #(.WIDTH(16), .FRAME(16), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr(clr),
    .dout_max(s_max), .dout_min(s_min), .max_idx(s_maxi), .min_idx(s_mini),
    .rdy(s_rdy), .busy(s_busy));

  maxmin_frame #(.WIDTH(16), .FRAME(16), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr(clr),
    .dout_max(u_max), .dout_min(u_min), .max_idx(u_maxi), .min_idx(u_mini),
    .rdy(u_rdy), .busy(u_busy));

  maxmin_frame #(.WIDTH(16), .FRAME(1), .SIGNED(1'b1)) dut_f (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr(clr),
    .dout_max(f_max), .dout_min(f_min), .max_idx(f_maxi), .min_idx(f_mini),
    .rdy(f_rdy), .busy(f_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; din_valid = 1'b0; clr = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (s_max !== 16'h0 || s_min !== 16'h0) begin n_fail++; $display("FAIL reset_s_vals: got %h/%h expected 0/0", s_max, s_min); end
    n_checks++; if (s_maxi !== 4'h0 || s_mini !== 4'h0) begin n_fail++; $display("FAIL reset_s_idx: got %0d/%0d expected 0/0", s_maxi, s_mini); end
    n_checks++; if (s_rdy !== 1'b0 || s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_s_flags: rdy=%b busy=%b expected 0/0", s_rdy, s_busy); end
    n_checks++; if (u_max !== 16'h0 || f_max !== 16'h0 || f_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_uf: u_max=%h f_max=%h f_rdy=%b expected 0", u_max, f_max, f_rdy); end
    #3 rst = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_alternating();
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b1;
      din = (i % 2 == 0) ? 16'(-(i + 1)) : 16'(i + 1);
      tick();
      if (i < 15) begin
        n_checks++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL alt_early_rdy: sample %0d rdy=%b expected 0", i, s_rdy); end
      end
    end
    $display("alt frame: s max=%h/%0d min=%h/%0d u max=%h/%0d min=%h/%0d", s_max, s_maxi, s_min, s_mini, u_max, u_maxi, u_min, u_mini);
    n_checks++; if (s_rdy !== 1'b1 || u_rdy !== 1'b1) begin n_fail++; $display("FAIL alt_rdy: got %b/%b expected 1/1", s_rdy, u_rdy); end
    n_checks++; if (s_max !== 16'd16 || s_maxi !== 4'd15) begin n_fail++; $display("FAIL alt_s_max: got %h/%0d expected 0010/15", s_max, s_maxi); end
    n_checks++; if (s_min !== 16'hFFF1 || s_mini !== 4'd14) begin n_fail++; $display("FAIL alt_s_min: got %h/%0d expected fff1/14", s_min, s_mini); end
    n_checks++; if (u_max !== 16'hFFFF || u_maxi !== 4'd0) begin n_fail++; $display("FAIL alt_u_max: got %h/%0d expected ffff/0", u_max, u_maxi); end
    n_checks++; if (u_min !== 16'd2 || u_mini !== 4'd1) begin n_fail++; $display("FAIL alt_u_min: got %h/%0d expected 0002/1", u_min, u_mini); end
    n_checks++; if (f_rdy !== 1'b1 || f_max !== 16'd16 || f_min !== 16'd16) begin n_fail++; $display("FAIL alt_f1: rdy=%b max=%h min=%h expected 1/0010/0010", f_rdy, f_max, f_min); end
    din_valid = 1'b0;
    tick();
    n_checks++; if (s_rdy !== 1'b0 || s_max !== 16'd16) begin n_fail++; $display("FAIL alt_pulse_hold: rdy=%b max=%h expected 0/0010", s_rdy, s_max); end
  endtask

  task automatic test_ties();
    int npulse = 0;
    int p1 = -1;
    int p2 = -1;
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b1; din = 16'd5;
      tick();
    end
    $display("ties frame: max=%0d/%0d min=%0d/%0d", s_max, s_maxi, s_min, s_mini);
    n_checks++; if (s_rdy !== 1'b1 || s_max !== 16'd5 || s_maxi !== 4'd0) begin n_fail++; $display("FAIL ties_max: rdy=%b got %0d/%0d expected 5/0", s_rdy, s_max, s_maxi); end
    n_checks++; if (s_min !== 16'd5 || s_mini !== 4'd0) begin n_fail++; $display("FAIL ties_min: got %0d/%0d expected 5/0", s_min, s_mini); end
    for (int j = 0; j < 32; j++) begin
      din = (j % 2 == 0) ? 16'd7 : 16'd3;
      tick();
      if (s_rdy === 1'b1) begin
        npulse++;
        if (p1 < 0) p1 = j; else p2 = j;
        $display("b2b frame: max=%0d/%0d min=%0d/%0d", s_max, s_maxi, s_min, s_mini);
        n_checks++; if (s_max !== 16'd7 || s_maxi !== 4'd0 || s_min !== 16'd3 || s_mini !== 4'd1) begin n_fail++; $display("FAIL b2b_vals: got %0d/%0d %0d/%0d expected 7/0 3/1", s_max, s_maxi, s_min, s_mini); end
      end
      if (j == 7) begin
        n_checks++; if (s_max !== 16'd5 || s_min !== 16'd5) begin n_fail++; $display("FAIL b2b_hold1: got %0d/%0d expected 5/5", s_max, s_min); end
      end
      if (j == 23) begin
        n_checks++; if (s_max !== 16'd7 || s_min !== 16'd3) begin n_fail++; $display("FAIL b2b_hold2: got %0d/%0d expected 7/3", s_max, s_min); end
      end
    end
    din_valid = 1'b0;
    n_checks++; if (npulse != 2 || p1 != 15 || p2 != 31) begin n_fail++; $display("FAIL b2b_spacing: pulses=%0d at %0d,%0d expected 2 at 15,31", npulse, p1, p2); end
  endtask

  task automatic test_gaps();
    int nrdy = 0;
    for (int c = 0; c < 32; c++) begin
      din_valid = (c % 2 == 0);
      din = 16'(10 + c / 2);
      tick();
      if (s_rdy === 1'b1) nrdy++;
      if (c < 30) begin
        n_checks++; if (s_busy !== 1'b1 || s_rdy !== 1'b0) begin n_fail++; $display("FAIL gap_busy: cycle %0d busy=%b rdy=%b expected 1/0", c, s_busy, s_rdy); end
      end else if (c == 30) begin
        $display("gap frame: max=%0d/%0d min=%0d/%0d", s_max, s_maxi, s_min, s_mini);
        n_checks++; if (s_rdy !== 1'b1 || s_busy !== 1'b0) begin n_fail++; $display("FAIL gap_done: rdy=%b busy=%b expected 1/0", s_rdy, s_busy); end
        n_checks++; if (s_max !== 16'd25 || s_maxi !== 4'd15 || s_min !== 16'd10 || s_mini !== 4'd0) begin n_fail++; $display("FAIL gap_vals: got %0d/%0d %0d/%0d expected 25/15 10/0", s_max, s_maxi, s_min, s_mini); end
      end
    end
    din_valid = 1'b0;
    n_checks++; if (nrdy != 1 || s_busy !== 1'b0) begin n_fail++; $display("FAIL gap_count: rdy pulses=%0d busy=%b expected 1/0", nrdy, s_busy); end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 7; i++) begin
      din_valid = 1'b1; din = 16'(50 + i);
      tick();
    end
    n_checks++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL clr_pre_busy: got %b expected 1", s_busy); end
    clr = 1'b1; din = 16'd100;
    tick();
    clr = 1'b0;
    $display("clr applied: busy=%b rdy=%b", s_busy, s_rdy);
    n_checks++; if (s_rdy !== 1'b0 || s_busy !== 1'b0 || f_rdy !== 1'b0) begin n_fail++; $display("FAIL clr_flags: rdy=%b busy=%b f_rdy=%b expected 0/0/0", s_rdy, s_busy, f_rdy); end
    n_checks++; if (s_max !== 16'd25 || s_min !== 16'd10) begin n_fail++; $display("FAIL clr_hold: got %0d/%0d expected 25/10", s_max, s_min); end
    for (int i = 0; i < 16; i++) begin
      din = 16'(40 - i);
      tick();
      if (i < 15) begin
        n_checks++; if (s_rdy !== 1'b0 || s_max !== 16'd25) begin n_fail++; $display("FAIL clr_early: sample %0d rdy=%b max=%0d expected 0/25", i, s_rdy, s_max); end
      end
    end
    din_valid = 1'b0;
    $display("post-clr frame: max=%0d/%0d min=%0d/%0d", s_max, s_maxi, s_min, s_mini);
    n_checks++; if (s_rdy !== 1'b1 || s_max !== 16'd40 || s_maxi !== 4'd0) begin n_fail++; $display("FAIL clr_max: rdy=%b got %0d/%0d expected 40/0", s_rdy, s_max, s_maxi); end
    n_checks++; if (s_min !== 16'd25 || s_mini !== 4'd15) begin n_fail++; $display("FAIL clr_min: got %0d/%0d expected 25/15", s_min, s_mini); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) begin
      din_valid = 1'b1; din = 16'(i + 1);
      tick();
    end
    din_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (s_max !== 16'h0 || s_min !== 16'h0 || s_maxi !== 4'h0 || s_mini !== 4'h0) begin n_fail++; $display("FAIL arst_vals: got %h/%0d %h/%0d expected 0", s_max, s_maxi, s_min, s_mini); end
    n_checks++; if (s_busy !== 1'b0 || s_rdy !== 1'b0 || u_max !== 16'h0) begin n_fail++; $display("FAIL arst_flags: busy=%b rdy=%b u_max=%h expected 0", s_busy, s_rdy, u_max); end
    #2 rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b1;
      din = (i == 0) ? 16'd200 : ((i == 3) ? 16'd1 : 16'd100);
      tick();
      if (i < 15) begin
        n_checks++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL arst_early: sample %0d rdy=%b expected 0", i, s_rdy); end
      end
    end
    din_valid = 1'b0;
    $display("post-reset frame: max=%0d/%0d min=%0d/%0d", s_max, s_maxi, s_min, s_mini);
    n_checks++; if (s_rdy !== 1'b1 || s_max !== 16'd200 || s_maxi !== 4'd0) begin n_fail++; $display("FAIL arst_max: rdy=%b got %0d/%0d expected 200/0", s_rdy, s_max, s_maxi); end
    n_checks++; if (s_min !== 16'd1 || s_mini !== 4'd3) begin n_fail++; $display("FAIL arst_min: got %0d/%0d expected 1/3", s_min, s_mini); end
  endtask

  task automatic test_frame1();
    logic [15:0] vals [4];
    vals[0] = 16'h8000; vals[1] = 16'h7FFF; vals[2] = 16'h0000; vals[3] = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'b1; din = vals[i];
      tick();
      $display("frame1 sample %0d: max=%h min=%h rdy=%b", i, f_max, f_min, f_rdy);
      n_checks++; if (f_rdy !== 1'b1 || f_max !== vals[i] || f_min !== vals[i] || f_maxi !== 1'b0 || f_mini !== 1'b0) begin n_fail++; $display("FAIL f1_sample%0d: rdy=%b max=%h min=%h idx=%0d/%0d expected 1 %h %h 0/0", i, f_rdy, f_max, f_min, f_maxi, f_mini, vals[i], vals[i]); end
    end
    din_valid = 1'b0;
    tick();
    n_checks++; if (f_rdy !== 1'b0 || f_max !== 16'h1234 || f_busy !== 1'b0) begin n_fail++; $display("FAIL f1_idle: rdy=%b max=%h busy=%b expected 0/1234/0", f_rdy, f_max, f_busy); end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_ties();
    test_gaps();
    test_clr();
    test_async_reset();
    test_frame1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxmin_frame.md
Name: maxmin_frame

Overview:
Streaming max/min tracker, parametrised successor to the fixed 16-bit maxmin block. Consumes a valid-qualified sample stream and splits it into frames of FRAME samples. For each frame it reports the maximum, the minimum, and the in-frame index of each, with a one-cycle rdy pulse. Comparison can be signed or unsigned, and a partial frame can be aborted with clr. It sits between a sample source and a downstream consumer that latches results on rdy.

Parameters:
WIDTH, 16, sample width in bits (>=2)
FRAME, 16, samples per frame (>=1)
SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare
IDXW, $clog2(FRAME) (min 1), width of the index outputs (derived; not to be overridden)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous active-low reset
din_valid  in  1  sample qualifier; a sample is accepted on every rising edge where din_valid=1 and clr=0
din  in  WIDTH  sample data
clr  in  1  synchronous abort of the partial frame
dout_max  out  WIDTH  frame maximum, held
dout_min  out  WIDTH  frame minimum, held
max_idx  out  IDXW  index 0..FRAME-1 of dout_max within its frame
min_idx  out  IDXW  index of dout_min within its frame
rdy  out  1  one-cycle pulse: new result on the outputs
busy  out  1  1 while a partial frame is held (cnt != 0)

Behaviour:
- Reset (rst=0, asynchronous): cnt, all running registers and all outputs = 0; state EMPTY. On release, the first accepted sample is index 0.
- States:
  - EMPTY (cnt=0).
  - ACCUM (0<cnt<FRAME).
  - Transitions: EMPTY->ACCUM on an accept when FRAME>1. ACCUM->EMPTY on the accept of sample FRAME-1, or on clr. EMPTY stays EMPTY on an accept when FRAME=1.
- Accept in EMPTY: run_max=run_min=din; run_maxi=run_mini=0; cnt=1.
- Accept in ACCUM:
  - run_max/run_maxi update only if din > run_max (strict, so the first occurrence wins ties).
  - run_min/run_mini update only if din < run_min (strict).
  - cnt increments.
- Compare rule: signed when SIGNED=1, unsigned otherwise. There is no arithmetic; values pass through at WIDTH bits.
- Frame completion: on the edge accepting sample index FRAME-1:
  - Outputs load from the running values merged with that final sample, using the same strict rule.
  - rdy=1 for exactly the following cycle.
  - cnt wraps to 0.
  - Latency is one edge from the last sample to rdy/valid outputs.
- Back-to-back frames: a sample accepted in the rdy cycle is index 0 of the next frame. There are no bubbles, and rdy pulses every FRAME accepted samples at full rate.
- Gaps: din_valid=0 freezes cnt and the running registers indefinitely.
- Output hold: dout_max, dout_min, max_idx and min_idx change only at frame completion. They hold between frames, across clr, and across gaps.
- clr:
  - Sets cnt=0 and discards the running values.
  - Takes priority over din_valid in the same cycle; that sample is dropped.
  - Does not touch the outputs or an rdy already asserted.
  - clr in EMPTY is a no-op.
- FRAME=1: every accepted sample produces rdy next cycle with dout_max=dout_min=din and both indices 0.
- busy = (cnt != 0), registered.

Decomposition:
- Shared package maxmin_pkg:
  - State encoding localparams (ST_EMPTY, ST_ACCUM).
  - A function or macro for the IDXW derivation, clamped to at least 1.
- One sub-module, maxmin_cmp (combinational, parameters WIDTH and SIGNED):
  - Inputs: candidate, current max, current min.
  - Outputs: gt_max, lt_min.
  - Instantiated once and used for both running update and final merge.

Test Plan:
- Reset, then 16 consecutive samples -1,2,-3,4,...,-15,16 (WIDTH=16, FRAME=16, SIGNED=1) -> single rdy one cycle after the 16th; dout_max=16, max_idx=15, dout_min=-15, min_idx=14.
- Same stream with SIGNED=0 -> dout_max=16'hFFFF (-1), max_idx=0; dout_min=2, min_idx=1.
- Ties: 16 samples all 5, then 32 samples 7,3,7,3,... as two frames back-to-back -> first rdy: 5/idx0, 5/idx0. Next two rdy pulses are 16 cycles apart: max 7 idx 0, min 3 idx 1. Outputs hold between pulses.
- Gaps: 16 samples with din_valid toggling every other cycle -> rdy after the 16th accepted sample; busy=1 throughout the frame and 0 after.
- clr after 7 samples, asserted together with din_valid=1 carrying 100, then a full 16-sample frame -> no rdy from the aborted frame and 100 absent from the result; the previous outputs are unchanged until the new rdy.
- Async reset mid-frame (rst=0 between edges after sample 9) -> all outputs 0 and busy=0 immediately; the next frame counts from index 0. Also check FRAME=1: each sample produces rdy with max=min=din.
